// File: rtl/wb_fwd_pipe_if.sv
// rtl/wb_fwd_pipe_if.sv - EX/MEM/ID side signal bundle for the writeback forwarding pipe
//
// Purpose: groups every non-clock, non-reset signal of wb_fwd_pipe.
//   slave  modport: the pipe itself (consumes EX/ID/control, produces buses).
//   master modport: the surrounding core (or bench) driving EX/ID/control.
// Signals:
//   ex_valid, ex_rf_we, ex_rf_waddr[4:0], ex_result[31:0], ex_is_load : EX stage
//   mem_load_data[31:0]                       : load data during the MEM cycle
//   hold, flush                               : pipeline control
//   id_raddr1/2[4:0], id_re1/2                : ID source operands
//   ex_to_id_bus/mem_to_id_bus/wb_to_id_bus   : {we, waddr[4:0], data[31:0]}
//   rf_we, rf_waddr[4:0], rf_wdata[31:0]      : regfile write port
//   stall_req, lu_stall_cnt[31:0]             : load-use stall and its counter
interface wb_fwd_pipe_if;
  logic        ex_valid;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [31:0] mem_load_data;
  logic        hold;
  logic        flush;
  logic [4:0]  id_raddr1;
  logic [4:0]  id_raddr2;
  logic        id_re1;
  logic        id_re2;
  logic [37:0] ex_to_id_bus;
  logic [37:0] mem_to_id_bus;
  logic [37:0] wb_to_id_bus;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] lu_stall_cnt;

  modport slave (
    input  ex_valid, ex_rf_we, ex_rf_waddr, ex_result, ex_is_load,
    input  mem_load_data, hold, flush,
    input  id_raddr1, id_raddr2, id_re1, id_re2,
    output ex_to_id_bus, mem_to_id_bus, wb_to_id_bus,
    output rf_we, rf_waddr, rf_wdata, stall_req, lu_stall_cnt
  );

  modport master (
    output ex_valid, ex_rf_we, ex_rf_waddr, ex_result, ex_is_load,
    output mem_load_data, hold, flush,
    output id_raddr1, id_raddr2, id_re1, id_re2,
    input  ex_to_id_bus, mem_to_id_bus, wb_to_id_bus,
    input  rf_we, rf_waddr, rf_wdata, stall_req, lu_stall_cnt
  );
endinterface

// File: rtl/wb_fwd_pipe.sv
// rtl/wb_fwd_pipe.sv - EX->MEM->WB destination pipe with ID forwarding buses and load-use stall
//
// Purpose: carries each instruction's register write from EX through MEM to WB,
//   drives the three ID forwarding buses and the regfile write port, and flags
//   load-use hazards that forwarding cannot cover.
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : wb_fwd_pipe_if.slave (EX/ID inputs, hold/flush, buses, regfile port, stall)
module wb_fwd_pipe (
  input  logic            clk,
  input  logic            rst,
  wb_fwd_pipe_if.slave    bus
);

  // MEM stage register
  logic        mem_valid;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic        mem_is_load;

  // WB stage register (already-resolved bus contents)
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;

  logic [31:0] stall_cnt;

  logic        ex_we_eff;
  logic        mem_we_eff;
  logic [31:0] mem_data;
  logic        hit1;
  logic        hit2;

  assign ex_we_eff  = bus.ex_valid & bus.ex_rf_we & (bus.ex_rf_waddr != 5'd0);
  assign mem_we_eff = mem_valid & mem_we & (mem_waddr != 5'd0);
  assign mem_data   = mem_is_load ? bus.mem_load_data : mem_result;

  // A load's value does not exist yet in EX, so it never forwards from there.
  assign bus.ex_to_id_bus  = {ex_we_eff & ~bus.ex_is_load, bus.ex_rf_waddr, bus.ex_result};
  assign bus.mem_to_id_bus = {mem_we_eff, mem_waddr, mem_data};
  assign bus.wb_to_id_bus  = {wb_we, wb_waddr, wb_data};

  // The WB bus stays live during hold; only the array write is deferred.
  assign bus.rf_we    = wb_we & ~bus.hold;
  assign bus.rf_waddr = wb_waddr;
  assign bus.rf_wdata = wb_data;

  assign hit1 = bus.id_re1 & (bus.id_raddr1 == bus.ex_rf_waddr);
  assign hit2 = bus.id_re2 & (bus.id_raddr2 == bus.ex_rf_waddr);
  assign bus.stall_req = ex_we_eff & bus.ex_is_load & (hit1 | hit2);

  assign bus.lu_stall_cnt = stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_waddr   <= 5'd0;
      mem_result  <= 32'd0;
      mem_is_load <= 1'b0;
    end else if (bus.flush) begin
      mem_valid   <= 1'b0;
    end else if (!bus.hold) begin
      mem_valid   <= bus.ex_valid;
      mem_we      <= bus.ex_rf_we;
      mem_waddr   <= bus.ex_rf_waddr;
      mem_result  <= bus.ex_result;
      mem_is_load <= bus.ex_is_load;
    end
  end

  // Flush only kills the younger instruction entering MEM; WB always completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we    <= 1'b0;
      wb_waddr <= 5'd0;
      wb_data  <= 32'd0;
    end else if (!bus.hold) begin
      wb_we    <= mem_we_eff;
      wb_waddr <= mem_waddr;
      wb_data  <= mem_data;
    end
  end

  // Counts every stalled cycle regardless of hold; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (bus.stall_req) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_fwd_pipe.sv
// tb/tb_wb_fwd_pipe.sv - directed self-checking bench for wb_fwd_pipe
module tb_wb_fwd_pipe;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_fwd_pipe_if ifc ();

  wb_fwd_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex_idle();
    ifc.ex_valid    = 1'b0;
    ifc.ex_rf_we    = 1'b0;
    ifc.ex_rf_waddr = 5'd0;
    ifc.ex_result   = 32'd0;
    ifc.ex_is_load  = 1'b0;
    ifc.id_raddr1   = 5'd0;
    ifc.id_raddr2   = 5'd0;
    ifc.id_re1      = 1'b0;
    ifc.id_re2      = 1'b0;
  endtask

  task automatic ex_issue(input logic [4:0] wa, input logic [31:0] res, input logic ld);
    ifc.ex_valid    = 1'b1;
    ifc.ex_rf_we    = 1'b1;
    ifc.ex_rf_waddr = wa;
    ifc.ex_result   = res;
    ifc.ex_is_load  = ld;
  endtask

  // Advance to the next negedge (one rising edge passes) and settle.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ex_idle();
    ifc.mem_load_data = 32'd0;
    ifc.hold  = 1'b0;
    ifc.flush = 1'b0;

    // Reset state
    #2;
    chk("rst_mem_bus", ifc.mem_to_id_bus, 38'd0);
    chk("rst_wb_bus",  ifc.wb_to_id_bus,  38'd0);
    chk("rst_rf_we",   {37'd0, ifc.rf_we}, 38'd0);
    chk("rst_cnt",     {6'd0, ifc.lu_stall_cnt}, 38'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // ALU bypass chain: r5 <= 0x1234
    ex_issue(5'd5, 32'h1234, 1'b0);
    #1;
    chk("alu_ex_bus", ifc.ex_to_id_bus, 38'h25_00001234);
    @(negedge clk);
    ex_idle();
    #1;
    chk("alu_mem_bus", ifc.mem_to_id_bus, 38'h25_00001234);
    chk("alu_ex_idle_we", {37'd0, ifc.ex_to_id_bus[37]}, 38'd0);
    next_cycle();
    chk("alu_wb_bus", ifc.wb_to_id_bus, 38'h25_00001234);
    chk("alu_rf_we", {37'd0, ifc.rf_we}, 38'd1);
    chk("alu_rf_waddr", {33'd0, ifc.rf_waddr}, 38'd5);
    chk("alu_rf_wdata", {6'd0, ifc.rf_wdata}, 38'h00_00001234);

    // Load to r7 with ID reading r7: no EX forwarding, stall requested
    @(negedge clk);
    ex_issue(5'd7, 32'h5555, 1'b1);
    ifc.id_raddr1 = 5'd7;
    ifc.id_re1    = 1'b1;
    #1;
    chk("ld_ex_we", {37'd0, ifc.ex_to_id_bus[37]}, 38'd0);
    chk("lu_stall_re1", {37'd0, ifc.stall_req}, 38'd1);
    chk("lu_cnt_before", {6'd0, ifc.lu_stall_cnt}, 38'd0);
    @(negedge clk);
    ex_idle();
    ifc.mem_load_data = 32'hDEADBEEF;
    #1;
    chk("ld_mem_bus", ifc.mem_to_id_bus, 38'h27_DEADBEEF);
    chk("lu_cnt_after", {6'd0, ifc.lu_stall_cnt}, 38'd1);
    chk("lu_stall_clear", {37'd0, ifc.stall_req}, 38'd0);
    next_cycle();
    chk("ld_rf_wdata", {6'd0, ifc.rf_wdata}, 38'h00_DEADBEEF);
    chk("ld_rf_we", {37'd0, ifc.rf_we}, 38'd1);
    chk("ld_rf_waddr", {33'd0, ifc.rf_waddr}, 38'd7);

    // Load-use negatives and second read port
    @(negedge clk);
    ifc.mem_load_data = 32'd0;
    ex_issue(5'd7, 32'h0, 1'b1);
    ifc.id_raddr1 = 5'd7;
    ifc.id_re1    = 1'b0;
    #1;
    chk("lu_re1_off", {37'd0, ifc.stall_req}, 38'd0);
    ifc.id_raddr2 = 5'd7;
    ifc.id_re2    = 1'b1;
    #1;
    chk("lu_re2_on", {37'd0, ifc.stall_req}, 38'd1);
    ifc.id_re2      = 1'b0;
    ifc.id_re1      = 1'b1;
    ifc.id_raddr1   = 5'd0;
    ifc.ex_rf_waddr = 5'd0;
    #1;
    chk("lu_waddr0", {37'd0, ifc.stall_req}, 38'd0);
    ex_idle();
    next_cycle();
    chk("lu_cnt_unchanged", {6'd0, ifc.lu_stall_cnt}, 38'd1);
    next_cycle();

    // Zero register never asserts a write
    ex_issue(5'd0, 32'hABCD, 1'b0);
    #1;
    chk("zero_ex_we", {37'd0, ifc.ex_to_id_bus[37]}, 38'd0);
    @(negedge clk);
    ex_idle();
    #1;
    chk("zero_mem_we", {37'd0, ifc.mem_to_id_bus[37]}, 38'd0);
    next_cycle();
    chk("zero_wb_we", {37'd0, ifc.wb_to_id_bus[37]}, 38'd0);
    chk("zero_rf_we", {37'd0, ifc.rf_we}, 38'd0);

    // Hold three cycles while WB has r3
    ex_issue(5'd3, 32'h33, 1'b0);
    @(negedge clk);
    ex_idle();
    @(negedge clk);
    ifc.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold_rf_we_%0d", i), {37'd0, ifc.rf_we}, 38'd0);
      chk($sformatf("hold_wb_bus_%0d", i), ifc.wb_to_id_bus, 38'h23_00000033);
      @(negedge clk);
    end
    ifc.hold = 1'b0;
    #1;
    chk("hold_release_we", {37'd0, ifc.rf_we}, 38'd1);
    chk("hold_release_addr", {33'd0, ifc.rf_waddr}, 38'd3);
    next_cycle();
    chk("hold_single_pulse", {37'd0, ifc.rf_we}, 38'd0);

    // Flush together with hold: r9 never reaches WB
    ex_issue(5'd9, 32'h99, 1'b0);
    @(negedge clk);
    ex_idle();
    #1;
    chk("flush_mem_before", ifc.mem_to_id_bus, 38'h29_00000099);
    ifc.flush = 1'b1;
    ifc.hold  = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    ifc.hold  = 1'b0;
    #1;
    chk("flush_mem_we", {37'd0, ifc.mem_to_id_bus[37]}, 38'd0);
    chk("flush_wb_we", {37'd0, ifc.wb_to_id_bus[37]}, 38'd0);
    next_cycle();
    chk("flush_wb_we2", {37'd0, ifc.wb_to_id_bus[37]}, 38'd0);
    chk("flush_rf_we", {37'd0, ifc.rf_we}, 38'd0);

    // Reset mid-stream
    ex_issue(5'd4, 32'h44, 1'b0);
    @(negedge clk);
    ex_issue(5'd6, 32'h66, 1'b0);
    #1;
    chk("rstm_mem_bus", ifc.mem_to_id_bus, 38'h24_00000044);
    @(negedge clk);
    ex_idle();
    #1;
    chk("rstm_wb_pre", ifc.wb_to_id_bus, 38'h24_00000044);
    rst = 1'b1;
    #1;
    chk("rstm_mem_bus0", ifc.mem_to_id_bus, 38'd0);
    chk("rstm_wb_bus0", ifc.wb_to_id_bus, 38'd0);
    chk("rstm_rf_we0", {37'd0, ifc.rf_we}, 38'd0);
    chk("rstm_rf_waddr0", {33'd0, ifc.rf_waddr}, 38'd0);
    chk("rstm_rf_wdata0", {6'd0, ifc.rf_wdata}, 38'd0);
    chk("rstm_cnt0", {6'd0, ifc.lu_stall_cnt}, 38'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rstm_no_write_%0d", i), {37'd0, ifc.rf_we}, 38'd0);
      @(negedge clk);
    end

    // Counter wrap
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    #1;
    chk("wrap_preset", {6'd0, ifc.lu_stall_cnt}, 38'h00_FFFFFFFF);
    ex_issue(5'd7, 32'h0, 1'b1);
    ifc.id_raddr1 = 5'd7;
    ifc.id_re1    = 1'b1;
    #1;
    chk("wrap_stall", {37'd0, ifc.stall_req}, 38'd1);
    @(negedge clk);
    #1;
    chk("wrap_cnt0", {6'd0, ifc.lu_stall_cnt}, 38'd0);

    // Stall while held still counts
    ifc.hold = 1'b1;
    @(negedge clk);
    ex_idle();
    ifc.hold = 1'b0;
    #1;
    chk("hold_stall_cnt", {6'd0, ifc.lu_stall_cnt}, 38'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
